// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous 2048x8 font ROM between three
// text-region requesters (0 = red, 1 = green, 2 = blue initials line).
// At most one request is granted per cycle; the ROM word returns one cycle
// later, tagged with a one-hot response valid.
//
// Ports:
//   clk                 pixel clock, all state on the rising edge
//   reset               asynchronous, active-high reset
//   req[2:0]            per-requester request, held until granted
//   char_addr_0..2      ASCII code per requester (7 bits)
//   row_addr_0..2       glyph row per requester (4 bits)
//   gnt[2:0]            one-hot grant, combinational
//   rom_addr[10:0]      {char_addr, row_addr} of the granted requester, else 0
//   rom_data[7:0]       ROM word, valid one cycle after rom_addr
//   rsp_valid[2:0]      registered one-hot response tag
//   rsp_data[7:0]       pass-through of rom_data
module font_rom_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned MAX_WAIT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [6:0]  char_addr_0,
  input  logic [6:0]  char_addr_1,
  input  logic [6:0]  char_addr_2,
  input  logic [3:0]  row_addr_0,
  input  logic [3:0]  row_addr_1,
  input  logic [3:0]  row_addr_2,
  output logic [2:0]  gnt,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [2:0]  rsp_valid,
  output logic [7:0]  rsp_data
);

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
  // With aging disabled the counters still run, but only up to 15.
  localparam logic [WAIT_W-1:0] SAT_W = (MAX_WAIT == 0) ? WAIT_W'(15) : WAIT_W'(MAX_WAIT);

  logic [1:0]        last_q;
  logic [WAIT_W-1:0] wait_q [N_REQ];
  logic [WAIT_W-1:0] wait_d [N_REQ];
  logic [2:0]        rsp_valid_q;

  logic [2:0] aged_c;
  logic [1:0] gnt_idx_c;
  logic       gnt_any_c;

  // Requesters that have waited MAX_WAIT cycles override normal priority.
  always_comb begin
    aged_c = 3'b000;
    for (int i = 0; i < N_REQ; i++) begin
      aged_c[i] = (MAX_WAIT != 0) && req[i] && (wait_q[i] == MAX_W);
    end
  end

  // Grant selection: aged (lowest index) > fixed or rotating priority.
  always_comb begin
    gnt_idx_c = 2'd0;
    gnt_any_c = 1'b0;
    if (aged_c != 3'b000) begin
      gnt_any_c = 1'b1;
      if (aged_c[0])      gnt_idx_c = 2'd0;
      else if (aged_c[1]) gnt_idx_c = 2'd1;
      else                gnt_idx_c = 2'd2;
    end else if (req != 3'b000) begin
      gnt_any_c = 1'b1;
      if (ROUND_ROBIN) begin
        // Search starts one past the last grant and wraps 2 -> 0.
        case (last_q)
          2'd0: begin
            if (req[1])      gnt_idx_c = 2'd1;
            else if (req[2]) gnt_idx_c = 2'd2;
            else             gnt_idx_c = 2'd0;
          end
          2'd1: begin
            if (req[2])      gnt_idx_c = 2'd2;
            else if (req[0]) gnt_idx_c = 2'd0;
            else             gnt_idx_c = 2'd1;
          end
          default: begin
            if (req[0])      gnt_idx_c = 2'd0;
            else if (req[1]) gnt_idx_c = 2'd1;
            else             gnt_idx_c = 2'd2;
          end
        endcase
      end else begin
        if (req[0])      gnt_idx_c = 2'd0;
        else if (req[1]) gnt_idx_c = 2'd1;
        else             gnt_idx_c = 2'd2;
      end
    end
    // Reset forces the grant low without waiting for a clock edge.
    if (reset) gnt_any_c = 1'b0;
  end

  assign gnt = gnt_any_c ? (3'b001 << gnt_idx_c) : 3'b000;

  // ROM address from the granted requester; zero when idle.
  always_comb begin
    rom_addr = 11'd0;
    case (gnt)
      3'b001:  rom_addr = {char_addr_0, row_addr_0};
      3'b010:  rom_addr = {char_addr_1, row_addr_1};
      3'b100:  rom_addr = {char_addr_2, row_addr_2};
      default: rom_addr = 11'd0;
    endcase
  end

  // Wait counters: clear when idle or granted, otherwise count and saturate.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || gnt[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != SAT_W) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= 2'd2;
      rsp_valid_q <= 3'b000;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      rsp_valid_q <= gnt;
      if (gnt_any_c) last_q <= gnt_idx_c;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rom_data;

endmodule
